// File: rtl/exp_range_reduce_if.sv
// Handshake/data bundle for exp_range_reduce: x in, r/k/flags out, valid/ready on each side.
interface exp_range_reduce_if #(
  parameter int K_W = 9
);
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out;
  logic [K_W-1:0] k;
  logic           nan;
  logic           ovf;
  logic           unf;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, k, nan, ovf, unf
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, k, nan, ovf, unf
  );
endinterface

// File: rtl/exp_range_reduce.sv
// Range reduction x = k*ln2 + r ahead of the Taylor e^x stage.
// One shared float multiplier and one float subtractor, sequenced by a 6-state FSM.
module exp_range_reduce #(
  parameter logic [31:0] LOG2E = 32'h3FB8AA3B,
  parameter logic [31:0] LN2   = 32'h3F317218,
  parameter int          K_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  exp_range_reduce_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SCALE, ROUND, MULK, SUB, OUT} state_e;

  localparam logic signed [8:0] K_POS = 9'sd128;
  localparam logic signed [8:0] K_NEG = -9'sd128;

  // Normalise m (bit 50 weighs 2^(e-127)) and round to nearest even.
  function automatic logic [31:0] norm_round(input logic s, input logic signed [10:0] e,
                                             input logic [50:0] m);
    logic [5:0]        lz;
    logic [50:0]       mn;
    logic [24:0]       rnd;
    logic signed [10:0] en;
    lz = '0;
    for (int unsigned i = 0; i < 51; i++) if (m[i]) lz = 6'(50 - i);
    mn  = m << lz;
    en  = e - signed'({5'b0, lz});
    rnd = {1'b0, mn[50:27]} + {24'b0, mn[26] & ((|mn[25:0]) | mn[27])};
    if (rnd[24]) begin
      en  = en + 11'sd1;
      rnd = rnd >> 1;
    end
    norm_round = (m == '0) ? '0 : {s, en[7:0], rnd[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]        prod;
    logic signed [10:0] e;
    prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e    = signed'({3'b0, a[30:23]}) + signed'({3'b0, b[30:23]}) - 11'sd126;
    if (a[30:23] == '0 || b[30:23] == '0) fmul = '0;
    else fmul = norm_round(a[31] ^ b[31], e, {prod, 3'b0});
  endfunction

  // a - b; alignment keeps 26 guard bits with a sticky folded into the LSB.
  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bn, hi, lo;
    logic [7:0]  d;
    logic [5:0]  dd;
    logic [50:0] bg, sm, sh;
    logic        st;
    bn = {~b[31], b[30:0]};
    if (a[30:0] >= bn[30:0]) begin
      hi = a;
      lo = bn;
    end else begin
      hi = bn;
      lo = a;
    end
    d     = hi[30:23] - lo[30:23];
    dd    = (d > 8'd50) ? 6'd50 : d[5:0];
    bg    = {1'b0, |hi[30:23], hi[22:0], 26'b0};
    sm    = {1'b0, |lo[30:23], lo[22:0], 26'b0};
    sh    = sm >> dd;
    st    = ((sh << dd) != sm);
    sh[0] = sh[0] | st;
    bg    = (hi[31] == lo[31]) ? bg + sh : bg - sh;
    fsub  = norm_round(hi[31], signed'({3'b0, hi[30:23]}) + 11'sd1, bg);
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       x_q, x_d, t_q, t_d, kf_q, kf_d, p_q, p_d, r_q, r_d;
  logic signed [8:0] k_q, k_d;
  logic              nan_c_q, nan_c_d, ovf_c_q, ovf_c_d, unf_c_q, unf_c_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [31:0]       out_q, out_d;
  logic [K_W-1:0]    kout_q, kout_d;
  logic              nan_q, nan_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [31:0]       mul_y, add_y, kflt;
  logic [7:0]        shv, kmag;
  logic [7:0]        xe;

  assign mul_y = (state_q == MULK) ? fmul(kf_q, LN2) : fmul(x_q, LOG2E);
  assign add_y = fsub(x_q, p_q);
  assign xe    = bus.in[30:23];

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    t_d         = t_q;
    k_d         = k_q;
    kf_d        = kf_q;
    p_d         = p_q;
    r_d         = r_q;
    nan_c_d     = nan_c_q;
    ovf_c_d     = ovf_c_q;
    unf_c_d     = unf_c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    kout_d      = kout_q;
    nan_d       = nan_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    shv         = '0;
    kmag        = '0;
    // |t| rounded half away from zero: keep one fraction bit, add half, drop it.
    if (t_q[30:23] >= 8'd126) begin
      shv  = 8'd149 - t_q[30:23];
      kmag = 8'(((25'({1'b1, t_q[22:0]}) >> shv) + 25'd1) >> 1);
    end
    kflt = norm_round(t_q[31], 11'sd134, {kmag, 43'b0});

    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        nan_c_d    = (xe == 8'hFF) && (bus.in[22:0] != '0);
        ovf_c_d    = !nan_c_d && (xe >= 8'd134) && !bus.in[31];
        unf_c_d    = !nan_c_d && (xe >= 8'd134) && bus.in[31];
        x_d        = (xe == '0 || xe >= 8'd134) ? '0 : bus.in;
        in_ready_d = 1'b0;
        state_d    = SCALE;
      end
      SCALE: begin
        t_d     = mul_y;
        state_d = ROUND;
      end
      ROUND: begin
        k_d     = t_q[31] ? -signed'({1'b0, kmag}) : signed'({1'b0, kmag});
        kf_d    = kflt;
        state_d = MULK;
      end
      MULK: begin
        p_d     = mul_y;
        state_d = SUB;
      end
      SUB: begin
        r_d     = add_y;
        state_d = OUT;
      end
      OUT: if (!out_valid_q) begin
        out_valid_d = 1'b1;
        nan_d       = nan_c_q;
        ovf_d       = ovf_c_q;
        unf_d       = unf_c_q;
        if (nan_c_q) begin
          out_d  = 32'h7FC00000;
          kout_d = '0;
        end else if (ovf_c_q) begin
          out_d  = '0;
          kout_d = K_W'(K_POS);
        end else if (unf_c_q) begin
          out_d  = '0;
          kout_d = K_W'(K_NEG);
        end else begin
          out_d  = r_q;
          kout_d = K_W'(k_q);
        end
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      t_q         <= '0;
      k_q         <= '0;
      kf_q        <= '0;
      p_q         <= '0;
      r_q         <= '0;
      nan_c_q     <= 1'b0;
      ovf_c_q     <= 1'b0;
      unf_c_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      kout_q      <= '0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      t_q         <= t_d;
      k_q         <= k_d;
      kf_q        <= kf_d;
      p_q         <= p_d;
      r_q         <= r_d;
      nan_c_q     <= nan_c_d;
      ovf_c_q     <= ovf_c_d;
      unf_c_q     <= unf_c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      kout_q      <= kout_d;
      nan_q       <= nan_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.k         = kout_q;
  assign bus.nan       = nan_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_exp_range_reduce.sv
// Directed and random checks of exp_range_reduce against a real-arithmetic reference.
module tb_exp_range_reduce;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_range_reduce_if #(.K_W(9)) bus ();

  exp_range_reduce #(
    .LOG2E (32'h3FB8AA3B),
    .LN2   (32'h3F317218),
    .K_W   (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  function automatic real pow2(input int n);
    real v;
    v = 1.0;
    if (n >= 0) repeat (n) v = v * 2.0;
    else repeat (-n) v = v / 2.0;
    return v;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -v : v;
  endfunction

  // Round a real to the nearest single (ties to even); inputs here are always exact in double.
  function automatic logic [31:0] r2f(input real v);
    real    a, m, fl;
    int     e;
    longint mi;
    logic   s;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a == 0.0) return 32'h0;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m  = a * 8388608.0;
    fl = $floor(m);
    mi = longint'(fl);
    if ((m - fl) > 0.5 || ((m - fl) == 0.5 && mi[0])) mi++;
    if (mi == 64'sd16777216) begin mi = mi >>> 1; e++; end
    return {s, 8'(e + 127), mi[22:0]};
  endfunction

  task automatic model(input logic [31:0] x, output logic [31:0] r, output logic [8:0] k,
                       output logic [2:0] flags);
    real xr, t, kr, p;
    int  ki;
    logic nan, big;
    nan   = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    big   = !nan && (x[30:23] >= 8'd134);
    flags = {nan, big && !x[31], big && x[31]};
    if (nan) begin
      r = 32'h7FC00000; k = 9'd0;
    end else if (big) begin
      r = 32'h0; k = x[31] ? 9'h180 : 9'h080;
    end else if (x[30:23] == 8'd0) begin
      r = 32'h0; k = 9'd0;
    end else begin
      xr = f2r(x);
      t  = f2r(r2f(xr * f2r(32'h3FB8AA3B)));
      kr = $floor(((t < 0.0) ? -t : t) + 0.5);
      ki = (t < 0.0) ? -int'(kr) : int'(kr);
      p  = f2r(r2f(real'(ki) * f2r(32'h3F317218)));
      r  = r2f(xr - p);
      k  = 9'(ki);
    end
  endtask

  function automatic int ordv(input logic [31:0] b);
    return b[31] ? -int'({1'b0, b[30:0]}) : int'({1'b0, b[30:0]});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    int   d;
    logic ok;
    d  = ordv(obs) - ordv(exp);
    if (d < 0) d = -d;
    ok = (d <= 2);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (+/-2ulp)", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("valid_ready_exclusive", 32'(bus.out_valid & bus.in_ready), 32'd0);
  endtask

  task automatic send(input logic [31:0] x);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in       = x;
    step();
    bus.in_valid = 1'b0;
    chk("in_ready_drop", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
  endtask

  task automatic check_out(input string tag, input logic [31:0] x);
    logic [31:0] er;
    logic [8:0]  ek;
    logic [2:0]  ef;
    model(x, er, ek, ef);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_k"}, 32'(bus.k), 32'(ek));
    chk({tag, "_flags"}, 32'({bus.nan, bus.ovf, bus.unf}), 32'(ef));
    if (ef != 3'b000 || x[30:23] == 8'd0) chk({tag, "_out"}, bus.out, er);
    else chk_ulp({tag, "_out"}, bus.out, er);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x);
    int lat;
    send(x);
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    check_out(tag, x);
    step();
    chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] specials [10];
    logic [31:0] x;
    real         v;
    int          lat;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = 32'h0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", bus.out, 32'h0);
    chk("rst_k", 32'(bus.k), 32'd0);
    chk("rst_flags", 32'({bus.nan, bus.ovf, bus.unf}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    run_op("t1_one", 32'h3F800000);
    run_op("t2_quarter", 32'h3E800000);
    run_op("t2_neg3", 32'hC0400000);

    specials = '{32'h7FC00001, 32'h43480000, 32'hFF800000, 32'h00000001, 32'h80000000,
                 32'h43000000, 32'hC3000000, 32'h42FE0000, 32'h7F800000, 32'hFFC00000};
    foreach (specials[i]) run_op($sformatf("t3_special%0d", i), specials[i]);

    // Back-pressure: result held, busy input ignored.
    bus.out_ready = 1'b0;
    send(32'h40A00000);
    wait_valid(lat);
    chk("t4_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in       = 32'h3F800000;
      end
      step();
      bus.in_valid = 1'b0;
      check_out("t4_hold", 32'h40A00000);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t4_release_ready", 32'(bus.in_ready), 32'd1);
    chk("t4_release_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_no_capture", 32'(bus.out_valid), 32'd0);
    end

    // Reset during MULK (two edges after accept).
    send(32'h40A00000);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_rst_k", 32'(bus.k), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    run_op("t5_after", 32'h3F800000);

    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) v = real'($urandom_range(0, 2000000)) / 1.0e9 - 0.001;
      else v = real'($urandom_range(0, 2540000)) / 10000.0 - 127.0;
      x = r2f(v);
      run_op("t6_random", x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
